// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle processor controller: states, opcodes,
// datapath mux selects and the decoded control word.
package multicycle_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_ILLEGAL  = 4'd15
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw (ungated) control word produced for one state.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       pc_write_cond;
        logic       illegal;
    } ctrl_t;

    // True for the last state of every instruction; leaving it retires one.
    function automatic logic retires(input state_e s);
        return (s == S_MEMWB)  || (s == S_MEMWRITE) || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_JUMP)     || (s == S_ADDIWB);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> control word decoder (Moore outputs).
module multicycle_ctrl_decode
    import multicycle_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // Every field defaults to 0; each state only raises what it needs.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.memto_reg = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
                ctrl_o.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            S_ILLEGAL: begin
                ctrl_o.illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore controller for the multicycle processor: state register, opcode
// dispatch, reset gating of strobes and a retired-instruction counter.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [RET_W-1:0] retired_q;
    ctrl_t            ctrl;

    // State register and retired counter; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retires(state_q)) begin
                retired_q <= retired_q + RET_W'(1);
            end
        end
    end

    // Next-state logic; Op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (Op == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // Strobes and enables are held low for as long as reset is asserted.
    assign MemRead  = ctrl.mem_read  & ~reset;
    assign MemWrite = ctrl.mem_write & ~reset;
    assign IRWrite  = ctrl.ir_write  & ~reset;
    assign RegWrite = ctrl.reg_write & ~reset;
    assign PCEn     = (ctrl.pc_write | (ctrl.pc_write_cond & Zero)) & ~reset;

    assign IorD     = ctrl.iord;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.memto_reg;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSrc    = ctrl.pc_src;
    assign illegal  = ctrl.illegal;
    assign state    = state_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes the expected
// state, control word and retired count for each cycle; a negedge monitor
// pops and compares against the DUT outputs.
module tb_multicycle_control;

    localparam int unsigned RET_W = 4;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    localparam logic [3:0] FE  = 4'd0;
    localparam logic [3:0] DE  = 4'd1;
    localparam logic [3:0] MA  = 4'd2;
    localparam logic [3:0] MR  = 4'd3;
    localparam logic [3:0] MWB = 4'd4;
    localparam logic [3:0] MW  = 4'd5;
    localparam logic [3:0] EX  = 4'd6;
    localparam logic [3:0] AWB = 4'd7;
    localparam logic [3:0] BR  = 4'd8;
    localparam logic [3:0] JU  = 4'd9;
    localparam logic [3:0] AE  = 4'd10;
    localparam logic [3:0] AWI = 4'd11;
    localparam logic [3:0] IL  = 4'd15;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       Op;
    logic             Zero;
    logic             IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
    logic             RegWrite, ALUSrcA, PCEn, illegal;
    logic [1:0]       ALUSrcB, ALUOp, PCSrc;
    logic [3:0]       state;
    logic [RET_W-1:0] retired;

    typedef struct {
        logic [3:0]       st;
        logic [15:0]      ctrl;
        logic [RET_W-1:0] ret;
        int               tag;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [15:0]      act_ctrl;
    logic [RET_W-1:0] ret_m;
    int               checks = 0;
    int               passes = 0;

    multicycle_control #(.RET_W(RET_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Zero     (Zero),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSrc    (PCSrc),
        .PCEn     (PCEn),
        .state    (state),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Hand table of required outputs per state:
    // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn,illegal}
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic z, input logic r);
        logic       iord, mr, mw, irw, rd, m2r, rw, sa, pcen, ill;
        logic [1:0] srcb, aop, pcs;
        {iord, mr, mw, irw, rd, m2r, rw, sa, pcen, ill} = '0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            FE:      begin mr = 1'b1; irw = 1'b1; srcb = 2'b01; pcen = 1'b1; end
            DE:      srcb = 2'b11;
            MA, AE:  begin sa = 1'b1; srcb = 2'b10; end
            MR:      begin mr = 1'b1; iord = 1'b1; end
            MW:      begin mw = 1'b1; iord = 1'b1; end
            MWB:     begin rw = 1'b1; m2r = 1'b1; end
            EX:      begin sa = 1'b1; aop = 2'b10; end
            AWB:     begin rw = 1'b1; rd = 1'b1; end
            AWI:     rw = 1'b1;
            BR:      begin sa = 1'b1; aop = 2'b01; pcs = 2'b01; pcen = z; end
            JU:      begin pcen = 1'b1; pcs = 2'b10; end
            IL:      ill = 1'b1;
            default: begin end
        endcase
        if (r) begin
            mr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; pcen = 1'b0;
        end
        return {iord, mr, mw, irw, rd, m2r, rw, sa, srcb, aop, pcs, pcen, ill};
    endfunction

    // One cycle: drive inputs just after the edge and queue what must be seen.
    task automatic cyc(input logic r, input logic [5:0] op, input logic z,
                       input logic [3:0] st, input int tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r;
        Op    = op;
        Zero  = z;
        e.st   = st;
        e.ctrl = exp_ctrl(st, z, r);
        e.ret  = ret_m;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // One whole instruction; Op is garbage outside the cycles that sample it.
    task automatic instr(input logic [5:0] op, input logic z, input logic [19:0] seq,
                         input int n, input int tag);
        for (int i = 0; i < n; i++) begin
            logic [5:0] o;
            o = (i == 1 || i == 2) ? op : BAD;
            cyc(1'b0, o, z, seq[19-4*i -: 4], tag);
        end
        ret_m = ret_m + RET_W'(1);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            act_ctrl = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                        ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal};
            checks++;
            if (state === mon_e.st) passes++;
            else $display("FAIL state tag=%0d got %0d want %0d", mon_e.tag, state, mon_e.st);
            checks++;
            if (act_ctrl === mon_e.ctrl) passes++;
            else $display("FAIL ctrl tag=%0d st=%0d got %b want %b", mon_e.tag, mon_e.st, act_ctrl, mon_e.ctrl);
            checks++;
            if (retired === mon_e.ret) passes++;
            else $display("FAIL retired tag=%0d got %0d want %0d", mon_e.tag, retired, mon_e.ret);
        end
    end

    initial begin
        reset = 1'b1;
        Op    = LW;
        Zero  = 1'b0;
        ret_m = '0;

        // Reset for three cycles, outputs gated
        repeat (3) cyc(1'b1, LW, 1'b0, FE, 0);

        instr(LW,   1'b1, {FE, DE, MA, MR, MWB},     5, 1);
        instr(SW,   1'b0, {FE, DE, MA, MW, 4'd0},    4, 2);
        instr(RT,   1'b1, {FE, DE, EX, AWB, 4'd0},   4, 3);
        instr(BEQ,  1'b1, {FE, DE, BR, 8'd0},        3, 4);
        instr(BEQ,  1'b0, {FE, DE, BR, 8'd0},        3, 5);
        instr(JMP,  1'b0, {FE, DE, JU, 8'd0},        3, 6);
        instr(ADDI, 1'b0, {FE, DE, AE, AWI, 4'd0},   4, 7);

        // Illegal opcode parks the controller; later Op values are ignored
        cyc(1'b0, BAD, 1'b0, FE, 8);
        cyc(1'b0, BAD, 1'b1, DE, 8);
        repeat (10) cyc(1'b0, LW, 1'b1, IL, 8);
        cyc(1'b1, LW, 1'b0, IL, 9);
        ret_m = '0;

        instr(JMP,  1'b0, {FE, DE, JU, 8'd0},        3, 10);

        // Reset asserted during MEMREAD aborts the lw before writeback
        cyc(1'b0, BAD, 1'b0, FE, 11);
        cyc(1'b0, LW,  1'b0, DE, 11);
        cyc(1'b0, LW,  1'b0, MA, 11);
        cyc(1'b1, LW,  1'b0, MR, 11);
        ret_m = '0;

        // Sixteen jumps wrap the 4-bit counter back to zero
        for (int k = 0; k < 16; k++) begin
            instr(JMP, 1'b0, {FE, DE, JU, 8'd0}, 3, 12 + k);
        end
        cyc(1'b0, BAD, 1'b0, FE, 28);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain %0d entries left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore finite-state controller for the multicycle processor. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the unified instruction/data memory's select, read and write strobes, plus the datapath's register, ALU and PC enables. It sits directly upstream of the memory and the datapath, and consumes the opcode held in the instruction register and the ALU zero flag.

## Interface
Parameters:
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Op  in  6  opcode field from the instruction register (bits 31:26).
- Zero  in  1  ALU zero flag.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = decode by funct.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC load enable = PCWrite | (PCWriteCond & Zero), combinational.
- state  out  4  current state, for debug.
- illegal  out  1  high while parked in ILLEGAL.
- retired  out  RET_W  count of completed instructions.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEXEC 10, ADDIWB 11, ILLEGAL 15. Codes 12–14 are unused and go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE dispatches on Op: 100011 (lw) and 101011 (sw) → MEMADR; 000000 (R-type) → EXECUTE; 000100 (beq) → BRANCH; 001000 (addi) → ADDIEXEC; 000010 (j) → JUMP; any other Op → ILLEGAL.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw. Op is re-checked here.
  - MEMREAD→MEMWB; EXECUTE→ALUWB; ADDIEXEC→ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, JUMP, ADDIWB → FETCH.
  - ILLEGAL → ILLEGAL until reset.
- Outputs are pure functions of state. Every output not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite=1; IorD=0; ALUSrcA=0; ALUSrcB=01; ALUOp=00; PCSrc=00.
  - DECODE: ALUSrcA=0; ALUSrcB=11; ALUOp=00.
  - MEMADR, ADDIEXEC: ALUSrcA=1; ALUSrcB=10; ALUOp=00.
  - MEMREAD: MemRead=1; IorD=1.
  - MEMWRITE: MemWrite=1; IorD=1.
  - MEMWB: RegWrite=1; MemtoReg=1; RegDst=0.
  - EXECUTE: ALUSrcA=1; ALUSrcB=00; ALUOp=10.
  - ALUWB: RegWrite=1; RegDst=1.
  - ADDIWB: RegWrite=1; RegDst=0; MemtoReg=0.
  - BRANCH: ALUSrcA=1; ALUSrcB=00; ALUOp=01; PCSrc=01; PCWriteCond=1.
  - JUMP: PCWrite=1; PCSrc=10.
  - ILLEGAL: illegal=1.
- MemRead is high only in FETCH and MEMREAD, and is never high in two consecutive states. Every memory access therefore starts with a fresh MemRead assertion.
- MemRead and MemWrite are never high together.
- retired increments by 1 on each edge that leaves MEMWB, MEMWRITE, ALUWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^RET_W. A not-taken beq still counts as retired.

## Timing
- Reset: a sampled-high reset forces state to FETCH and sets retired=0.
  - While reset is high, all strobe and enable outputs are gated to 0: MemRead, MemWrite, IRWrite, RegWrite, PCEn.
  - Reset has priority over every transition, including in ILLEGAL and in mid-instruction.
  - The first FETCH cycle is the first cycle in which reset is low.
- CPI: lw 5; sw, R-type and addi 4; beq and j 3.
- Op is sampled only in DECODE and MEMADR. Op changes in other states have no effect.
- Zero affects PCEn only in BRANCH, and does so combinationally within that cycle.

## Structure
- Package multicycle_pkg holds:
  - the state encoding constants;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALUOp, ALUSrcB and PCSrc encodings.
- One sub-module, multicycle_ctrl_decode: combinational state → control-word decoder. The top holds the state register, next-state logic, reset gating and the retired counter.

## Test plan
- Reset held 3 cycles, then released with Op=100011 → state 0,1,2,3,4,0. MemRead high in cycles 1 and 4 (IorD 0 then 1). RegWrite high in cycle 5. retired=1.
- Op=101011 → FETCH, DECODE, MEMADR, MEMWRITE, FETCH. MemWrite=1 and IorD=1 for exactly one cycle. RegWrite never high.
- Op=000100 with Zero=1 in BRANCH → PCEn=1 and PCSrc=01 there. Repeat with Zero=0 → PCEn=0. In both cases retired increments and the instruction takes 3 cycles.
- Op=000010 → JUMP with PCWrite=1 and PCSrc=10. Op=001000 → ADDIEXEC then ADDIWB with RegDst=0 and MemtoReg=0.
- Op=111111 → ILLEGAL with illegal=1 and all strobes 0 for 10 cycles. Then reset=1 for 1 cycle → FETCH and retired=0.
- Preload retired to 2^32−1 via a run of j instructions, or force it → the next completion gives retired=0. Assert reset in MEMREAD → next state is FETCH and RegWrite never pulses.
